// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding (IDLE/RUN/DONE) and latency constant for sequential arithmetic units
package arith_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} sub_state_e;
  localparam int SUB_LAT_EXTRA = 1;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit combinational cell, d = a^b^bin, bout = borrow out (ports a, b, bin -> d, bout)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b-bin, LSB first, start/ready/busy/done handshake; ovf port only with SUB_OVF_EN
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  sub_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic br_q, br_d, bout_q, bout_d, d_bit, br_next, accept, run, last;
  full_subtractor u_fs (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (br_q),
    .d   (d_bit),
    .bout(br_next)
  );
  always_comb begin
    accept = state_q == IDLE && start;
    run = state_q == RUN;
    last = run && cnt_q == LAST;
    state_d = accept ? RUN : last ? DONE : run ? RUN : IDLE;
    cnt_d = accept ? '0 : (run && !last) ? cnt_q + CW'(1) : cnt_q;
    a_d = accept ? a : run ? a_q >> 1 : a_q;
    b_d = accept ? b : run ? b_q >> 1 : b_q;
    br_d = accept ? bin : run ? br_next : br_q;
    diff_d = run ? {d_bit, diff_q[WIDTH-1:1]} : diff_q;
    bout_d = last ? br_next : bout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      br_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      br_q <= br_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end
  assign ready = state_q == IDLE;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_OVF_EN
  logic am_q, am_d, bm_q, bm_d, ovf_q, ovf_d;
  always_comb begin
    am_d = accept ? a[WIDTH-1] : am_q;
    bm_d = accept ? b[WIDTH-1] : bm_q;
    ovf_d = last ? (am_q != bm_q) & (d_bit != am_q) : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      am_q <= 1'b0;
      bm_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      am_q <= am_d;
      bm_q <= bm_d;
      ovf_q <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized scoreboard bench for serial_subtractor (WIDTH=4), ovf checked when SUB_OVF_EN is defined
module tb_serial_subtractor;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, bin = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic ready, busy, done, bout;
  logic [3:0] diff;
`ifdef SUB_OVF_EN
  logic ovf;
`endif
  typedef struct {
    logic [3:0] diff;
    logic bout;
    logic ovf;
    int cyc;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  logic [3:0] last_diff = '0;
  logic last_bout = 1'b0, mon_en = 1'b0;
  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SUB_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(logic [3:0] x, logic [3:0] y, logic bi, int c);
    exp_t e;
    int r, sx, sy, rs;
    r = int'(x) - int'(y) - int'(bi);
    sx = x > 4'd7 ? int'(x) - 16 : int'(x);
    sy = y > 4'd7 ? int'(y) - 16 : int'(y);
    rs = sx - sy - int'(bi);
    e.diff = r[3:0];
    e.bout = r < 0;
    e.ovf = rs < -8 || rs > 7;
    e.cyc = c;
    return e;
  endfunction
  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", int'(ready), 1);
  endtask
  task automatic issue(logic [3:0] x, logic [3:0] y, logic bi);
    wait_ready();
    a = x;
    b = y;
    bin = bi;
    start = 1'b1;
    q.push_back(model(x, y, bi, cyc + 5));
    @(negedge clk);
    start = 1'b0;
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot_state", int'(ready) + int'(busy) + int'(done), 1);
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("diff", int'(diff), int'(e.diff));
          chk("bout", int'(bout), int'(e.bout));
`ifdef SUB_OVF_EN
          chk("ovf", int'(ovf), int'(e.ovf));
`endif
          chk("done_cycle", cyc, e.cyc);
          last_diff = e.diff;
          last_bout = e.bout;
        end
      end else if (ready) begin
        chk("hold_diff", int'(diff), int'(last_diff));
        chk("hold_bout", int'(bout), int'(last_bout));
      end
    end
  end
  initial begin
    int n, nacc, prev;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_bout", int'(bout), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    issue(4'd9, 4'd3, 1'b0);
    n = 1;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_again_cycle", n, 6);
    issue(4'd3, 4'd9, 1'b0);
    issue(4'd0, 4'd0, 1'b1);
    issue(4'd15, 4'd15, 1'b1);
    issue(4'd15, 4'd0, 1'b0);
    issue(4'd9, 4'd3, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a = 4'd1;
    b = 4'd14;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a = 4'd2;
    @(negedge clk);
    start = 1'b0;
    issue(4'd12, 4'd5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    last_diff = '0;
    last_bout = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", int'(ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_diff", int'(diff), 0);
    chk("abort_bout", int'(bout), 0);
    repeat (8) @(negedge clk);
`ifdef SUB_OVF_EN
    issue(4'd7, 4'd15, 1'b0);
    issue(4'd8, 4'd1, 1'b0);
    issue(4'd5, 4'd2, 1'b0);
    issue(4'd8, 4'd0, 1'b1);
`endif
    wait_ready();
    start = 1'b1;
    nacc = 0;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      if (ready) begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        bin = 1'($urandom_range(0, 1));
        q.push_back(model(a, b, bin, cyc + 5));
        if (nacc > 0) chk("held_interval", cyc - prev, 6);
        prev = cyc;
        nacc++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("held_accepts", nacc, 4);
    for (int i = 0; i < 30; i++)
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
